zynet_cfg_loader: RTL

AXI4-Lite master that configures the zyNet accelerator from an on-chip parameter ROM, with no processor in the loop. After a start pulse it clears zyNet's soft reset, then loads every neuron's weights and biases, layer by layer. It sits directly upstream of zyNet's AXI4-Lite slave port and drives its configuration registers. It replaces the processor-driven config sequence, so a standalone build can start classifying after power-up.

---
 rtl/zynet_cfg_loader_if.sv | 25 ++
 rtl/zynet_cfg_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/zynet_cfg_loader_if.sv
// AXI4-Lite write-only channel bundle between the config loader (master) and
// the zyNet configuration slave.
interface zynet_cfg_loader_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/zynet_cfg_loader.sv
// Processor-less zyNet configurator: replays soft-reset clear, then weight and
// bias loading from a parameter ROM as AXI4-Lite writes.
module zynet_cfg_loader #(
    parameter int          DATA_WIDTH    = 16,
    parameter int          NUM_LAYERS    = 1,
    parameter logic [31:0] LAYER_NEURONS = 32'd30,
    parameter logic [63:0] LAYER_WEIGHTS = 64'd784,
    parameter int          ROM_AW        = 16
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    zynet_cfg_loader_if.master    m_axi
);

    typedef enum logic [2:0] {IDLE, ROM_RD, ROM_CAP, ISSUE, RESP, NEXT, FIN} state_t;
    typedef enum logic [2:0] {K_SRST, K_LAYER, K_NEURON, K_WEIGHT, K_BIAS} kind_t;

    localparam logic [31:0] REG_WEIGHT = 32'd0;
    localparam logic [31:0] REG_BIAS   = 32'd4;
    localparam logic [31:0] REG_LAYER  = 32'd12;
    localparam logic [31:0] REG_NEURON = 32'd16;
    localparam logic [31:0] REG_SRST   = 32'd28;
    localparam logic [2:0]  LAST_LAYER = 3'(NUM_LAYERS - 1);

    state_t      state, state_n;
    kind_t       kind, kind_n;
    logic [2:0]  layer, layer_n;
    logic [7:0]  neuron, neuron_n;
    logic [15:0] wcnt, wcnt_n;
    logic        pass, pass_n;
    logic        rom_used;
    logic        seq_end;
    logic [7:0]  n_cur;
    logic [15:0] w_cur;
    logic [31:0] next_addr, next_data;

    assign m_axi.awprot = 3'b000;
    assign m_axi.wstrb  = 4'hF;
    assign m_axi.bready = (state == RESP);
    assign busy         = (state != IDLE) && (state != FIN);
    assign done         = (state == FIN);

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) state <= IDLE;
        else              state <= state_n;
    end

    // Counter walk order: layer register, then per neuron the neuron register
    // followed by its weights (pass 0) or its single bias (pass 1).
    always_comb begin
        case (layer)
            3'd0:    begin n_cur = LAYER_NEURONS[7:0];   w_cur = LAYER_WEIGHTS[15:0];  end
            3'd1:    begin n_cur = LAYER_NEURONS[15:8];  w_cur = LAYER_WEIGHTS[31:16]; end
            3'd2:    begin n_cur = LAYER_NEURONS[23:16]; w_cur = LAYER_WEIGHTS[47:32]; end
            default: begin n_cur = LAYER_NEURONS[31:24]; w_cur = LAYER_WEIGHTS[63:48]; end
        endcase

        kind_n   = kind;
        layer_n  = layer;
        neuron_n = neuron;
        wcnt_n   = wcnt;
        pass_n   = pass;
        seq_end  = 1'b0;
        case (kind)
            K_SRST: begin
                kind_n  = K_LAYER;
                layer_n = 3'd0;
                pass_n  = 1'b0;
            end
            K_LAYER: begin
                kind_n   = K_NEURON;
                neuron_n = 8'd0;
            end
            K_NEURON: begin
                kind_n = pass ? K_BIAS : K_WEIGHT;
                wcnt_n = 16'd0;
            end
            K_WEIGHT, K_BIAS: begin
                if (kind == K_WEIGHT && wcnt != w_cur - 16'd1) begin
                    wcnt_n = wcnt + 16'd1;
                end else if (neuron != n_cur - 8'd1) begin
                    neuron_n = neuron + 8'd1;
                    kind_n   = K_NEURON;
                end else if (layer != LAST_LAYER) begin
                    layer_n = layer + 3'd1;
                    kind_n  = K_LAYER;
                end else if (!pass) begin
                    pass_n  = 1'b1;
                    layer_n = 3'd0;
                    kind_n  = K_LAYER;
                end else begin
                    seq_end = 1'b1;
                end
            end
            default: kind_n = K_SRST;
        endcase

        case (kind_n)
            K_LAYER:  begin next_addr = REG_LAYER;  next_data = 32'(layer_n) + 32'd1; end
            K_NEURON: begin next_addr = REG_NEURON; next_data = 32'(neuron_n);        end
            K_WEIGHT: begin next_addr = REG_WEIGHT; next_data = 32'd0;                end
            K_BIAS:   begin next_addr = REG_BIAS;   next_data = 32'd0;                end
            default:  begin next_addr = REG_SRST;   next_data = 32'd0;                end
        endcase

        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ISSUE;
            ROM_RD:  state_n = ROM_CAP;
            ROM_CAP: state_n = ISSUE;
            ISSUE: begin
                if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready))
                    state_n = RESP;
            end
            RESP: begin
                if (m_axi.bvalid) state_n = (m_axi.bresp != 2'b00) ? FIN : NEXT;
            end
            NEXT: begin
                if (seq_end)                                    state_n = FIN;
                else if (kind_n == K_WEIGHT || kind_n == K_BIAS) state_n = ROM_RD;
                else                                            state_n = ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The first ROM read uses address 0 as-is; later reads step it first so the
    // address always names the word currently in flight.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            kind          <= K_SRST;
            layer         <= 3'd0;
            neuron        <= 8'd0;
            wcnt          <= 16'd0;
            pass          <= 1'b0;
            rom_used      <= 1'b0;
            rom_addr      <= '0;
            err           <= 1'b0;
            m_axi.awaddr  <= 32'd0;
            m_axi.wdata   <= 32'd0;
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        kind          <= K_SRST;
                        layer         <= 3'd0;
                        neuron        <= 8'd0;
                        wcnt          <= 16'd0;
                        pass          <= 1'b0;
                        rom_used      <= 1'b0;
                        rom_addr      <= '0;
                        err           <= 1'b0;
                        m_axi.awaddr  <= REG_SRST;
                        m_axi.wdata   <= 32'd0;
                        m_axi.awvalid <= 1'b1;
                        m_axi.wvalid  <= 1'b1;
                    end
                end
                ROM_CAP: begin
                    m_axi.wdata   <= 32'(rom_data);
                    m_axi.awvalid <= 1'b1;
                    m_axi.wvalid  <= 1'b1;
                end
                ISSUE: begin
                    if (m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
                end
                RESP: begin
                    if (m_axi.bvalid && m_axi.bresp != 2'b00) err <= 1'b1;
                end
                NEXT: begin
                    kind         <= kind_n;
                    layer        <= layer_n;
                    neuron       <= neuron_n;
                    wcnt         <= wcnt_n;
                    pass         <= pass_n;
                    m_axi.awaddr <= next_addr;
                    if (state_n == ISSUE) begin
                        m_axi.wdata   <= next_data;
                        m_axi.awvalid <= 1'b1;
                        m_axi.wvalid  <= 1'b1;
                    end
                    if (state_n == ROM_RD) begin
                        if (rom_used) rom_addr <= rom_addr + ROM_AW'(1);
                        rom_used <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
